// File: rtl/uart_loader.sv
// uart_loader: byte-stream boot loader fed by a UART receiver.
// It parses SYNC, LEN_LO, LEN_HI, 4*LEN payload bytes and CSUM. Payload words are
// written to memory as they complete. The core is held in reset until a packet
// with a correct checksum has been loaded.
//
// Ports:
//   clk        sole clock, rising edge
//   reset      asynchronous active-high reset
//   rx_data    received byte, qualified by rx_valid
//   rx_valid   one-cycle strobe per received byte
//   mem_we     one-cycle memory write strobe
//   mem_addr   word address of the write (holds until the next write)
//   mem_wdata  write data (holds until the next write)
//   busy       packet in progress
//   done       one-cycle pulse: packet accepted, checksum correct
//   error      one-cycle pulse: checksum mismatch or inter-byte timeout
//   cpu_hold   core reset request (level)
module uart_loader #(
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned BASE_ADDR    = 0,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter int unsigned TIMEOUT_CLKS = 1000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  cpu_hold
);

  localparam int unsigned GapW = (TIMEOUT_CLKS < 2) ? 1 : $clog2(TIMEOUT_CLKS + 1);
  localparam logic [GapW-1:0] GapMax  = {GapW{1'b1}};
  localparam logic [GapW-1:0] GapLast = GapW'(TIMEOUT_CLKS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLenLo,
    StLenHi,
    StData,
    StCsum
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [15:0]           r_len, w_len_nxt;
  logic [15:0]           r_word_idx, w_word_idx_nxt;
  logic [1:0]            r_byte_cnt, w_byte_cnt_nxt;
  logic [23:0]           r_word, w_word_nxt;
  logic [7:0]            r_csum, w_csum_nxt;
  logic [GapW-1:0]       r_gap, w_gap_nxt;
  logic                  r_mem_we, w_mem_we_nxt;
  logic [ADDR_WIDTH-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [31:0]           r_mem_wdata, w_mem_wdata_nxt;
  logic                  r_busy, w_busy_nxt;
  logic                  r_done, w_done_nxt;
  logic                  r_error, w_error_nxt;
  logic                  r_cpu_hold, w_cpu_hold_nxt;
  logic                  w_timeout;
  logic [ADDR_WIDTH-1:0] w_addr;

  // Address wraps naturally by truncation to ADDR_WIDTH bits.
  assign w_addr = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(r_word_idx);

  // A byte arriving in the expiry cycle wins over the timeout.
  assign w_timeout = (r_state != StIdle) && !rx_valid && (r_gap == GapLast);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= StIdle;
      r_len       <= '0;
      r_word_idx  <= '0;
      r_byte_cnt  <= '0;
      r_word      <= '0;
      r_csum      <= '0;
      r_gap       <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_cpu_hold  <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_len       <= w_len_nxt;
      r_word_idx  <= w_word_idx_nxt;
      r_byte_cnt  <= w_byte_cnt_nxt;
      r_word      <= w_word_nxt;
      r_csum      <= w_csum_nxt;
      r_gap       <= w_gap_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_error     <= w_error_nxt;
      r_cpu_hold  <= w_cpu_hold_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_len_nxt       = r_len;
    w_word_idx_nxt  = r_word_idx;
    w_byte_cnt_nxt  = r_byte_cnt;
    w_word_nxt      = r_word;
    w_csum_nxt      = r_csum;
    w_mem_we_nxt    = 1'b0;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_done_nxt      = 1'b0;
    w_error_nxt     = 1'b0;
    w_cpu_hold_nxt  = r_cpu_hold;

    // Gap counter: idle in IDLE, cleared by every byte, saturating otherwise.
    if (r_state == StIdle || rx_valid) begin
      w_gap_nxt = '0;
    end else if (r_gap != GapMax) begin
      w_gap_nxt = r_gap + GapW'(1);
    end else begin
      w_gap_nxt = r_gap;
    end

    case (r_state)
      StIdle: begin
        if (rx_valid && rx_data == SYNC_BYTE) begin
          w_state_nxt    = StLenLo;
          w_csum_nxt     = '0;
          w_cpu_hold_nxt = 1'b1;
        end
      end
      StLenLo: begin
        if (rx_valid) begin
          w_len_nxt[7:0] = rx_data;
          w_csum_nxt     = r_csum ^ rx_data;
          w_state_nxt    = StLenHi;
        end
      end
      StLenHi: begin
        if (rx_valid) begin
          w_len_nxt[15:8] = rx_data;
          w_csum_nxt      = r_csum ^ rx_data;
          w_word_idx_nxt  = '0;
          w_byte_cnt_nxt  = '0;
          w_state_nxt     = ({rx_data, r_len[7:0]} != 16'd0) ? StData : StCsum;
        end
      end
      StData: begin
        if (rx_valid) begin
          w_csum_nxt     = r_csum ^ rx_data;
          w_byte_cnt_nxt = r_byte_cnt + 2'd1;
          case (r_byte_cnt)
            2'd0:    w_word_nxt[7:0]   = rx_data;
            2'd1:    w_word_nxt[15:8]  = rx_data;
            2'd2:    w_word_nxt[23:16] = rx_data;
            default: begin
              w_mem_we_nxt    = 1'b1;
              w_mem_addr_nxt  = w_addr;
              w_mem_wdata_nxt = {rx_data, r_word};
              w_word_idx_nxt  = r_word_idx + 16'd1;
              if (r_word_idx == r_len - 16'd1) begin
                w_state_nxt = StCsum;
              end
            end
          endcase
        end
      end
      StCsum: begin
        if (rx_valid) begin
          if (rx_data == r_csum) begin
            w_done_nxt     = 1'b1;
            w_cpu_hold_nxt = 1'b0;
          end else begin
            w_error_nxt = 1'b1;
          end
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase

    if (w_timeout) begin
      w_state_nxt = StIdle;
      w_error_nxt = 1'b1;
    end

    w_busy_nxt = (w_state_nxt != StIdle);
  end

  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = r_busy;
  assign done      = r_done;
  assign error     = r_error;
  assign cpu_hold  = r_cpu_hold;

endmodule

// File: tb/tb_uart_loader.sv
module tb_uart_loader;

  localparam int unsigned TO = 50;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_valid2;

  logic        mem_we, busy, done, error, cpu_hold;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we2, busy2, done2, error2, cpu_hold2;
  logic [1:0]  mem_addr2;
  logic [31:0] mem_wdata2;

  always #5 clk = ~clk;

  uart_loader #(
    .ADDR_WIDTH  (10),
    .BASE_ADDR   (0),
    .SYNC_BYTE   (8'hA5),
    .TIMEOUT_CLKS(TO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .cpu_hold (cpu_hold)
  );

  uart_loader #(
    .ADDR_WIDTH  (2),
    .BASE_ADDR   (3),
    .SYNC_BYTE   (8'hA5),
    .TIMEOUT_CLKS(TO)
  ) dut2 (
    .clk      (clk),
    .reset    (reset),
    .rx_data  (rx_data),
    .rx_valid (rx_valid2),
    .mem_we   (mem_we2),
    .mem_addr (mem_addr2),
    .mem_wdata(mem_wdata2),
    .busy     (busy2),
    .done     (done2),
    .error    (error2),
    .cpu_hold (cpu_hold2)
  );

  int vectors = 0;
  int miscompares = 0;

  // Monitor, sampled on the falling edge.
  logic [31:0] got_addr[$];
  logic [31:0] got_data[$];
  logic [31:0] got2_addr[$];
  logic [31:0] got2_data[$];
  int done_cnt = 0;
  int err_cnt = 0;
  int done2_cnt = 0;

  always @(negedge clk) begin
    if (mem_we) begin
      got_addr.push_back(32'(mem_addr));
      got_data.push_back(mem_wdata);
    end
    if (mem_we2) begin
      got2_addr.push_back(32'(mem_addr2));
      got2_data.push_back(mem_wdata2);
    end
    if (done) done_cnt++;
    if (error) err_cnt++;
    if (done2) done2_cnt++;
  end

  // Reference packet: words to load, serialized byte stream.
  logic [31:0] words[$];
  logic [7:0]  pkt[$];
  bit          use2 = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic build(input bit bad);
    logic [7:0] cs;
    logic [31:0] n;
    logic [31:0] w;
    n = 32'(words.size());
    pkt.delete();
    pkt.push_back(8'hA5);
    pkt.push_back(n[7:0]);
    pkt.push_back(n[15:8]);
    cs = n[7:0] ^ n[15:8];
    foreach (words[i]) begin
      w = words[i];
      for (int b = 0; b < 4; b++) begin
        pkt.push_back(w[8*b +: 8]);
        cs = cs ^ w[8*b +: 8];
      end
    end
    pkt.push_back(bad ? ~cs : cs);
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    rx_data = b;
    if (use2) rx_valid2 = 1'b1;
    else rx_valid = 1'b1;
    @(negedge clk);
    rx_valid  = 1'b0;
    rx_valid2 = 1'b0;
    rx_data   = 8'($urandom);
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_pkt(input int max_gap);
    foreach (pkt[i]) send(pkt[i], int'($urandom_range(0, max_gap)));
  endtask

  task automatic clear_mon();
    got_addr.delete();
    got_data.delete();
    got2_addr.delete();
    got2_data.delete();
  endtask

  // Expected result of one packet on the main DUT: every word written in order at
  // BASE + index (mod 1024), then exactly one done or error.
  task automatic check_packet(input string tag, input bit bad, input int d0, input int e0);
    repeat (3) @(negedge clk);
    check({tag, "_nwrites"}, 32'(got_addr.size()), 32'(words.size()));
    for (int i = 0; i < words.size() && i < got_addr.size(); i++) begin
      check({tag, "_addr"}, got_addr[i], 32'(i % 1024));
      check({tag, "_data"}, got_data[i], words[i]);
    end
    check({tag, "_done"}, 32'(done_cnt - d0), bad ? 32'd0 : 32'd1);
    check({tag, "_error"}, 32'(err_cnt - e0), bad ? 32'd1 : 32'd0);
    check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'(bad));
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int d0, e0, seen;
    logic [7:0] junk;
    bit bad;

    reset     = 1'b1;
    rx_valid  = 1'b0;
    rx_valid2 = 1'b0;
    rx_data   = 8'h00;
    repeat (3) @(negedge clk);

    // Reset values.
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Directed good packet.
    words = '{32'h44332211, 32'h88776655};
    build(1'b0);
    check("dir_csum_byte", 32'(pkt[pkt.size()-1]), 32'(8'h02 ^ 8'h00 ^ 8'h88));
    clear_mon();
    d0 = done_cnt; e0 = err_cnt;
    send(pkt[0], 0);
    check("dir_busy_after_sync", 32'(busy), 32'd1);
    for (int i = 1; i < pkt.size(); i++) send(pkt[i], 1);
    check_packet("dir_good", 1'b0, d0, e0);

    // Same packet, checksum inverted.
    build(1'b1);
    clear_mon();
    d0 = done_cnt; e0 = err_cnt;
    send_pkt(0);
    check_packet("dir_bad", 1'b1, d0, e0);

    // Leading junk ignored, then zero-length packet.
    clear_mon();
    d0 = done_cnt; e0 = err_cnt;
    send(8'h00, 1); send(8'hFF, 0); send(8'h5A, 2);
    check("junk_busy", 32'(busy), 32'd0);
    check("junk_no_error", 32'(err_cnt - e0), 32'd0);
    words.delete();
    build(1'b0);
    check("zero_len_pkt_size", 32'(pkt.size()), 32'd4);
    send_pkt(1);
    check_packet("zero_len", 1'b0, d0, e0);

    // Timeout: gaps of TO-1 idle cycles are tolerated, then a stall fires error
    // exactly TO edges after the last strobe.
    clear_mon();
    e0 = err_cnt;
    send(8'hA5, 0);
    send(8'h01, TO - 1);
    send(8'h00, 0);
    send(8'h11, TO - 1);
    send(8'h22, 0);
    check("to_boundary_no_error", 32'(err_cnt - e0), 32'd0);
    seen = -1;
    for (int k = 1; k <= TO + 10; k++) begin
      @(negedge clk);
      if (k == TO - 1) check("to_busy_before", 32'(busy), 32'd1);
      if (error && seen < 0) seen = k;
    end
    check("to_error_cycle", 32'(seen), 32'(TO));
    check("to_error_count", 32'(err_cnt - e0), 32'd1);
    check("to_no_write", 32'(got_addr.size()), 32'd0);
    check("to_busy_after", 32'(busy), 32'd0);
    check("to_cpu_hold", 32'(cpu_hold), 32'd1);

    // Narrow address space wraps: BASE 3, two words -> 3 then 0.
    clear_mon();
    d0 = done2_cnt;
    words = '{32'($urandom), 32'($urandom)};
    build(1'b0);
    use2 = 1'b1;
    send_pkt(2);
    use2 = 1'b0;
    repeat (3) @(negedge clk);
    check("wrap_nwrites", 32'(got2_addr.size()), 32'd2);
    if (got2_addr.size() == 2) begin
      check("wrap_addr0", got2_addr[0], 32'd3);
      check("wrap_addr1", got2_addr[1], 32'd0);
      check("wrap_data0", got2_data[0], words[0]);
      check("wrap_data1", got2_data[1], words[1]);
    end
    check("wrap_done", 32'(done2_cnt - d0), 32'd1);
    check("wrap_cpu_hold", 32'(cpu_hold2), 32'd0);

    // Randomized packets, some with leading junk, some with bad checksums.
    for (int p = 0; p < 16; p++) begin
      words.delete();
      for (int i = 0; i < int'($urandom_range(0, 5)); i++) words.push_back(32'($urandom));
      bad = ($urandom_range(0, 3) == 0);
      build(bad);
      clear_mon();
      d0 = done_cnt; e0 = err_cnt;
      if ($urandom_range(0, 1) == 1) begin
        junk = 8'($urandom);
        if (junk == 8'hA5) junk = 8'h5A;
        send(junk, int'($urandom_range(0, 2)));
      end
      send_pkt(3);
      check_packet("rand", bad, d0, e0);
    end

    // Reset after the 6th byte aborts asynchronously without error or write.
    words = '{32'hCAFEF00D, 32'h12345678, 32'hA5A5A5A5};
    build(1'b0);
    clear_mon();
    e0 = err_cnt;
    for (int i = 0; i < 6; i++) send(pkt[i], 0);
    #2;
    reset = 1'b1;
    #1;
    check("arst_mem_we", 32'(mem_we), 32'd0);
    check("arst_mem_addr", 32'(mem_addr), 32'd0);
    check("arst_mem_wdata", mem_wdata, 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_cpu_hold", 32'(cpu_hold), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("arst_no_error", 32'(err_cnt - e0), 32'd0);
    check("arst_no_write", 32'(got_addr.size()), 32'd0);
    d0 = done_cnt; e0 = err_cnt;
    send_pkt(1);
    check_packet("after_rst", 1'b0, d0, e0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
